// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the 5-stage RV64 pipeline.
// Owns the program counter, presents it to instruction memory, and registers the
// returned word plus its PC into the IF/ID pipeline register.
//
// Ports:
//   clk               pipeline clock, rising-edge
//   reset_n           asynchronous active-low reset
//   stall             hold PC, IF/ID and fetch_count
//   flush             replace IF/ID with a bubble, PC still advances
//   branch_taken      redirect PC to branch_target (word aligned), bubble IF/ID
//   branch_target     redirect byte address
//   inst_address      byte address to instruction memory (== PC register)
//   instruction_in    word read combinationally from instruction memory
//   if_id_pc          PC of the instruction in IF/ID
//   if_id_pc_plus4    if_id_pc + 4
//   if_id_instruction instruction in IF/ID (NOP_INSTR when bubbled)
//   if_id_valid       IF/ID holds a real fetched instruction
//   fetch_count       valid instructions latched since reset (wraps)
module instruction_fetch_unit #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   output logic [63:0] inst_address,
   input  logic [31:0] instruction_in,
   output logic [63:0] if_id_pc,
   output logic [63:0] if_id_pc_plus4,
   output logic [31:0] if_id_instruction,
   output logic        if_id_valid,
   output logic [31:0] fetch_count
);

   logic [63:0] pc_q, pc_d;
   logic [63:0] if_id_pc_q, if_id_pc_d;
   logic [63:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
   logic [31:0] if_id_instruction_q, if_id_instruction_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [63:0] pc_plus4;

   // Target low bits are dropped: fetch is always word aligned.
   logic unused_target_bits;
   assign unused_target_bits = ^branch_target[1:0];

   assign pc_plus4 = pc_q + 64'd4;

   always_comb begin
      pc_d                = pc_q;
      if_id_pc_d          = if_id_pc_q;
      if_id_pc_plus4_d    = if_id_pc_plus4_q;
      if_id_instruction_d = if_id_instruction_q;
      if_id_valid_d       = if_id_valid_q;
      fetch_count_d       = fetch_count_q;

      if (branch_taken) begin
         // Redirect overrides stall and flush; IF/ID pc fields keep old values.
         pc_d                = {branch_target[63:2], 2'b00};
         if_id_instruction_d = NOP_INSTR;
         if_id_valid_d       = 1'b0;
      end else if (flush) begin
         // Word at the current PC is discarded but the PC still moves on.
         pc_d                = pc_plus4;
         if_id_instruction_d = NOP_INSTR;
         if_id_valid_d       = 1'b0;
      end else if (!stall) begin
         pc_d                = pc_plus4;
         if_id_pc_d          = pc_q;
         if_id_pc_plus4_d    = pc_plus4;
         if_id_instruction_d = instruction_in;
         if_id_valid_d       = 1'b1;
         fetch_count_d       = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q                <= RESET_PC;
         if_id_pc_q          <= 64'd0;
         if_id_pc_plus4_q    <= 64'd0;
         if_id_instruction_q <= NOP_INSTR;
         if_id_valid_q       <= 1'b0;
         fetch_count_q       <= 32'd0;
      end else begin
         pc_q                <= pc_d;
         if_id_pc_q          <= if_id_pc_d;
         if_id_pc_plus4_q    <= if_id_pc_plus4_d;
         if_id_instruction_q <= if_id_instruction_d;
         if_id_valid_q       <= if_id_valid_d;
         fetch_count_q       <= fetch_count_d;
      end
   end

   assign inst_address      = pc_q;
   assign if_id_pc          = if_id_pc_q;
   assign if_id_pc_plus4    = if_id_pc_plus4_q;
   assign if_id_instruction = if_id_instruction_q;
   assign if_id_valid       = if_id_valid_q;
   assign fetch_count       = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a reference model produces the
// expected IF state for each edge, pushes it to a scoreboard queue, and the entry
// is popped and compared shortly after the edge.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [63:0] inst_address;
   logic [31:0] instruction_in;
   logic [63:0] if_id_pc;
   logic [63:0] if_id_pc_plus4;
   logic [31:0] if_id_instruction;
   logic        if_id_valid;
   logic [31:0] fetch_count;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] ifpc;
      logic [63:0] pc4;
      logic [31:0] instr;
      logic        valid;
      logic [31:0] cnt;
   } exp_t;

   exp_t m;
   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   instruction_fetch_unit #(
      .RESET_PC (64'h0),
      .NOP_INSTR(NOP)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .stall            (stall),
      .flush            (flush),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .inst_address     (inst_address),
      .instruction_in   (instruction_in),
      .if_id_pc         (if_id_pc),
      .if_id_pc_plus4   (if_id_pc_plus4),
      .if_id_instruction(if_id_instruction),
      .if_id_valid      (if_id_valid),
      .fetch_count      (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: four program words, a recognisable pattern elsewhere.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      case (a)
         64'd0:   return 32'h0004_3483;
         64'd4:   return 32'h0084_84B3;
         64'd8:   return 32'h009A_84B3;
         64'd12:  return 32'h0014_8493;
         default: return {16'hA5A5, a[17:2]};
      endcase
   endfunction

   assign instruction_in = mem_word(inst_address);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic compare(input string tag, input exp_t e);
      check({tag, ".addr"},  inst_address, e.pc);
      check({tag, ".pc"},    if_id_pc, e.ifpc);
      check({tag, ".pc4"},   if_id_pc_plus4, e.pc4);
      check({tag, ".instr"}, {32'd0, if_id_instruction}, {32'd0, e.instr});
      check({tag, ".valid"}, {63'd0, if_id_valid}, {63'd0, e.valid});
      check({tag, ".count"}, {32'd0, fetch_count}, {32'd0, e.cnt});
   endtask

   task automatic model_reset();
      m.pc    = 64'd0;
      m.ifpc  = 64'd0;
      m.pc4   = 64'd0;
      m.instr = NOP;
      m.valid = 1'b0;
      m.cnt   = 32'd0;
   endtask

   // Drive one edge worth of control, update the model, push, then pop after the edge.
   task automatic step(input string tag, input logic st, input logic fl, input logic br,
                       input logic [63:0] tgt);
      exp_t e;
      stall         = st;
      flush         = fl;
      branch_taken  = br;
      branch_target = tgt;
      if (br) begin
         m.pc    = {tgt[63:2], 2'b00};
         m.instr = NOP;
         m.valid = 1'b0;
      end else if (fl) begin
         m.pc    = m.pc + 64'd4;
         m.instr = NOP;
         m.valid = 1'b0;
      end else if (!st) begin
         m.ifpc  = m.pc;
         m.pc4   = m.pc + 64'd4;
         m.instr = mem_word(m.pc);
         m.valid = 1'b1;
         m.pc    = m.pc + 64'd4;
         m.cnt   = m.cnt + 32'd1;
      end
      sb_q.push_back(m);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb_q.pop_front();
         compare(tag, e);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #3;
      model_reset();
      compare("reset", m);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      stall         = 1'b0;
      flush         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 64'd0;
      reset_n       = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      do_reset();

      // Four free-running fetches.
      for (int i = 0; i < 4; i++) step("seq", 1'b0, 1'b0, 1'b0, 64'd0);
      check("seq.final_addr", inst_address, 64'd16);

      // Stall after the second fetch.
      do_reset();
      step("f1", 1'b0, 1'b0, 1'b0, 64'd0);
      step("f2", 1'b0, 1'b0, 1'b0, 64'd0);
      for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 1'b0, 64'd0);
      step("unstall", 1'b0, 1'b0, 1'b0, 64'd0);
      check("unstall.instr", {32'd0, if_id_instruction}, 64'h009A_84B3);

      // Branch during stall, misaligned target.
      step("br_stall", 1'b1, 1'b0, 1'b1, 64'h6);
      check("br_stall.addr4", inst_address, 64'd4);
      step("after_br", 1'b0, 1'b0, 1'b0, 64'd0);

      // Flush alone at pc=8, then stall+flush together.
      check("pre_flush.addr8", inst_address, 64'd8);
      step("flush", 1'b0, 1'b1, 1'b0, 64'd0);
      step("stall_flush", 1'b1, 1'b1, 1'b0, 64'd0);
      // Flush and branch together: branch wins.
      step("br_flush", 1'b0, 1'b1, 1'b1, 64'h20);

      // PC wrap.
      step("br_top", 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      step("wrap", 1'b0, 1'b0, 1'b0, 64'd0);
      check("wrap.pc4_zero", if_id_pc_plus4, 64'd0);

      // Mid-cycle asynchronous reset.
      do_reset();
      for (int i = 0; i < 3; i++) step("pre_async", 1'b0, 1'b0, 1'b0, 64'd0);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      compare("async_rst", m);
      #1;
      reset_n = 1'b1;
      step("restart0", 1'b0, 1'b0, 1'b0, 64'd0);
      step("restart1", 1'b0, 1'b0, 1'b0, 64'd0);

      // Random control mix.
      for (int i = 0; i < 40; i++) begin
         logic [63:0] t;
         t = {32'd0, 16'd0, 16'($urandom_range(0, 255))};
         step("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 6) == 0), t);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
